rf_writeback_arbiter: RTL and testbench
=======================================

Name: rf_writeback_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: ALU results and memory loads.
- Uses round-robin arbitration with valid/ready handshakes and drives the write port through registered outputs.
- Keeps a pending-write scoreboard so that issue logic stalls on read-after-write hazards against in-flight destinations.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_W, 32, writeback data width.
- ADDR_W, 5, register address width.
- NREG, 32, number of architectural registers (2**ADDR_W).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Alu_Valid  in  1  ALU writeback request.
- Alu_Dest  in  ADDR_W  ALU destination register.
- Alu_Data  in  DATA_W  ALU result.
- Alu_Ready  out  1  ALU request accepted this cycle.
- Mem_Valid  in  1  load writeback request.
- Mem_Dest  in  ADDR_W  load destination register.
- Mem_Data  in  DATA_W  load data.
- Mem_Ready  out  1  load request accepted this cycle.
- Issue_En  in  1  an instruction with a destination wants to issue.
- Issue_Dest  in  ADDR_W  destination of the issuing instruction.
- Rd_A  in  ADDR_W  source register A of the issuing instruction.
- Rd_B  in  ADDR_W  source register B of the issuing instruction.
- Stall  out  1  issue blocked by a hazard.
- RF_Write_En  out  1  register file write enable.
- RF_Add_Dest  out  ADDR_W  register file write address.
- RF_Write_Data  out  DATA_W  register file write data.
- Grant_Src  out  1  source of the current RF write (0 = ALU, 1 = MEM).

Behaviour:
- Reset (async, RST_N=0):
  - RF_Write_En=0, RF_Add_Dest=0, RF_Write_Data=0, Grant_Src=0.
  - pending[NREG-1:0]=0.
  - last_grant=MEM, so the ALU wins the first contended cycle.
  - Any accepted but uncommitted write is dropped.
- Handshake:
  - A transfer occurs when Valid and Ready are both high at a rising edge.
  - Ready is combinational from the grant logic. At most one Ready is high per cycle.
  - Sources hold Valid, Dest and Data stable until accepted.
- Arbitration:
  - Only one Valid high: grant it.
  - Both Valid high: grant the source opposite last_grant.
  - last_grant updates to the granted source on every grant.
- Write timing:
  - A request accepted at edge N produces RF_Write_En=1 with the registered Dest, Data and Grant_Src throughout cycle N+1.
  - The register file commits the write at edge N+1.
  - With no grant, RF_Write_En=0 in the next cycle; address and data hold their last values.
  - Back-to-back grants sustain one write per cycle.
- Register 0:
  - A request with Dest=0 is accepted normally (Ready high).
  - RF_Write_En stays 0 for it; pending[0] is never set.
- Scoreboard:
  - Issue is accepted when Issue_En=1 and Stall=0. Acceptance sets pending[Issue_Dest] at the edge if Issue_Dest≠0.
  - pending[RF_Add_Dest] clears at the edge where RF_Write_En=1, i.e. when the write actually commits.
  - Set and clear on the same register at the same edge: set wins, because the new issue is younger.
- Stall (combinational):
  - Stall = Issue_En & ( (Rd_A≠0 & pending[Rd_A]) | (Rd_B≠0 & pending[Rd_B]) | (Issue_Dest≠0 & pending[Issue_Dest]) ).
  - The WAW term guarantees at most one outstanding write per register.
  - A register being committed in the current cycle still reads as pending; Stall releases the following cycle (no bypass).
- Writeback to a non-pending register (nonzero Dest) is legal and simply writes. A simulation-only assertion flags it.

Decomposition:
- Package rf_pkg:
  - constants DATA_W, ADDR_W, NREG;
  - SRC_ALU=1'b0, SRC_MEM=1'b1;
  - typedef wb_req_t {valid, dest, data}.
- One sub-module: rf_scoreboard.
  - Contains the pending vector and its set/clear logic.
  - Provides the hazard lookups for Rd_A, Rd_B and Issue_Dest, and outputs Stall.
- The arbiter and the output register stay in the top module.

Test Plan:
1. Reset, then Alu_Valid=1 (Dest=5, Data=0xDEADBEEF) for one cycle → Alu_Ready=1 at the accepting edge; the next cycle shows RF_Write_En=1, RF_Add_Dest=5, RF_Write_Data=0xDEADBEEF, Grant_Src=0.
2. Both Valid held for 4 cycles (ALU Dest=1, MEM Dest=2; each source drops Valid after acceptance, then re-raises with Dest+2) → grants alternate ALU, MEM, ALU, MEM; RF writes go to regs 1, 2, 3, 4 on consecutive cycles.
3. Issue_En with Issue_Dest=7 → pending[7]=1. Next instruction has Rd_A=7 → Stall=1. Mem writeback to Dest=7 accepted at edge N, committed at edge N+1 → Stall=1 through cycle N+1, Stall=0 in cycle N+2.
4. Alu_Valid with Dest=0, Data=0x1234 → Alu_Ready=1; RF_Write_En stays 0. Issue with Rd_A=0, Rd_B=0 → Stall=0.
5. Same edge: commit to reg 9 and accepted issue of Issue_Dest=9 → pending[9] remains 1. A later Rd_B=9 → Stall=1.
6. Deassert RST_N mid-cycle while a write is accepted and pending bits are set → all outputs 0 immediately; pending cleared; after release, the ALU wins the first contention.

Source files
------------

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared constants and types for the register-file writeback arbiter.
//   DATA_W   : writeback data width
//   ADDR_W   : register address width
//   NREG     : number of architectural registers (2**ADDR_W)
//   SRC_ALU  : grant source code for the ALU writeback path
//   SRC_MEM  : grant source code for the load writeback path
//   wb_req_t : one writeback request as presented by a source
// -----------------------------------------------------------------------------
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 1 << ADDR_W;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_writeback_arbiter_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Pending-write scoreboard. One bit per architectural register marks a
// destination that has been issued but whose writeback has not yet committed
// to the register file. Issue is stalled on RAW hazards (either source) and on
// WAW hazards (destination), which keeps at most one write in flight per
// register. Register 0 is hard-wired and never tracked.
//
// Ports:
//   clk_i          : clock, rising edge
//   rst_ni         : asynchronous active-low reset, clears all pending bits
//   issue_en_i     : an instruction with a destination wants to issue
//   issue_dest_i   : its destination register
//   rd_a_i, rd_b_i : its source registers
//   commit_en_i    : register file write commits at this edge
//   commit_dest_i  : register being written
//   stall_o        : issue blocked by a hazard (combinational)
//   pending_o      : current pending vector
// -----------------------------------------------------------------------------
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int NREG   = rf_pkg::NREG
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_en_i,
  input  logic [ADDR_W-1:0] issue_dest_i,
  input  logic [ADDR_W-1:0] rd_a_i,
  input  logic [ADDR_W-1:0] rd_b_i,
  input  logic              commit_en_i,
  input  logic [ADDR_W-1:0] commit_dest_i,
  output logic              stall_o,
  output logic [NREG-1:0]   pending_o
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  logic hit_a;
  logic hit_b;
  logic hit_dest;
  logic issue_acc;

  // No bypass: a register committing this cycle still reads as pending, so
  // a dependent instruction releases one cycle after the commit edge.
  assign hit_a    = (rd_a_i       != '0) && pending_q[rd_a_i];
  assign hit_b    = (rd_b_i       != '0) && pending_q[rd_b_i];
  assign hit_dest = (issue_dest_i != '0) && pending_q[issue_dest_i];

  assign stall_o   = issue_en_i && (hit_a || hit_b || hit_dest);
  assign issue_acc = issue_en_i && !stall_o;

  // Clear is applied before set so that a younger issue to the register
  // being committed at the same edge keeps its pending bit.
  always_comb begin
    pending_d = pending_q;
    if (commit_en_i) begin
      pending_d[commit_dest_i] = 1'b0;
    end
    if (issue_acc && (issue_dest_i != '0)) begin
      pending_d[issue_dest_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/rf_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// rf_writeback_arbiter
// Shares the register file's single write port between the ALU and load
// writeback paths. Round-robin arbitration with valid/ready handshakes; the
// winning request is registered and presented to the register file for one
// cycle. A pending-write scoreboard stalls issue on in-flight destinations.
//
// Ports:
//   CLK, RST_N                      : clock (rising edge), async active-low reset
//   Alu_Valid/Dest/Data, Alu_Ready  : ALU writeback request and acceptance
//   Mem_Valid/Dest/Data, Mem_Ready  : load writeback request and acceptance
//   Issue_En, Issue_Dest, Rd_A, Rd_B: issuing instruction (destination, sources)
//   Stall                           : issue blocked by a hazard
//   RF_Write_En/Add_Dest/Write_Data : registered register-file write port
//   Grant_Src                       : source of the current write (0 ALU, 1 MEM)
// -----------------------------------------------------------------------------
module rf_writeback_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int NREG   = rf_pkg::NREG
) (
  input  logic              CLK,
  input  logic              RST_N,

  input  logic              Alu_Valid,
  input  logic [ADDR_W-1:0] Alu_Dest,
  input  logic [DATA_W-1:0] Alu_Data,
  output logic              Alu_Ready,

  input  logic              Mem_Valid,
  input  logic [ADDR_W-1:0] Mem_Dest,
  input  logic [DATA_W-1:0] Mem_Data,
  output logic              Mem_Ready,

  input  logic              Issue_En,
  input  logic [ADDR_W-1:0] Issue_Dest,
  input  logic [ADDR_W-1:0] Rd_A,
  input  logic [ADDR_W-1:0] Rd_B,
  output logic              Stall,

  output logic              RF_Write_En,
  output logic [ADDR_W-1:0] RF_Add_Dest,
  output logic [DATA_W-1:0] RF_Write_Data,
  output logic              Grant_Src
);

  logic              last_grant_q;
  logic              last_grant_d;

  logic              we_q;
  logic              we_d;
  logic [ADDR_W-1:0] dest_q;
  logic [ADDR_W-1:0] dest_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              src_q;
  logic              src_d;

  logic              alu_gnt;
  logic              mem_gnt;
  logic              grant;
  logic [ADDR_W-1:0] sel_dest;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   pending;

  // Round-robin: an uncontended request always wins; under contention the
  // source that did not win last time is granted. last_grant resets to MEM
  // so the ALU wins the first contended cycle.
  always_comb begin
    alu_gnt  = Alu_Valid && (!Mem_Valid || (last_grant_q == SRC_MEM));
    mem_gnt  = Mem_Valid && (!Alu_Valid || (last_grant_q == SRC_ALU));
    grant    = alu_gnt || mem_gnt;
    sel_dest = mem_gnt ? Mem_Dest : Alu_Dest;
    sel_data = mem_gnt ? Mem_Data : Alu_Data;
  end

  assign Alu_Ready = alu_gnt;
  assign Mem_Ready = mem_gnt;

  // A grant to register 0 completes the handshake but never drives the
  // write enable; address/data/source only move on a real write so the
  // port keeps describing the last committed write.
  always_comb begin
    last_grant_d = last_grant_q;
    we_d         = grant && (sel_dest != '0);
    dest_d       = dest_q;
    data_d       = data_q;
    src_d        = src_q;
    if (grant) begin
      last_grant_d = mem_gnt ? SRC_MEM : SRC_ALU;
    end
    if (we_d) begin
      dest_d = sel_dest;
      data_d = sel_data;
      src_d  = mem_gnt ? SRC_MEM : SRC_ALU;
    end
  end

  // Output register: a request accepted at edge N is on the write port for
  // the whole of cycle N+1 and commits at edge N+1. Reset drops any
  // accepted-but-uncommitted write.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_grant_q <= SRC_MEM;
      we_q         <= 1'b0;
      dest_q       <= '0;
      data_q       <= '0;
      src_q        <= SRC_ALU;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      dest_q       <= dest_d;
      data_q       <= data_d;
      src_q        <= src_d;
    end
  end

  assign RF_Write_En   = we_q;
  assign RF_Add_Dest   = dest_q;
  assign RF_Write_Data = data_q;
  assign Grant_Src     = src_q;

  // The pending bit of the written register clears on the commit edge,
  // i.e. the edge at which RF_Write_En is high.
  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_scoreboard (
    .clk_i         (CLK),
    .rst_ni        (RST_N),
    .issue_en_i    (Issue_En),
    .issue_dest_i  (Issue_Dest),
    .rd_a_i        (Rd_A),
    .rd_b_i        (Rd_B),
    .commit_en_i   (we_q),
    .commit_dest_i (dest_q),
    .stall_o       (Stall),
    .pending_o     (pending)
  );

`ifndef SYNTHESIS
  a_one_ready : assert property (@(posedge CLK) disable iff (!RST_N)
    !(Alu_Ready && Mem_Ready))
    else $error("both writeback sources granted in one cycle");

  // Legal but unexpected: a writeback whose destination was never issued.
  a_wb_pending : assert property (@(posedge CLK) disable iff (!RST_N)
    (grant && (sel_dest != '0)) |-> pending[sel_dest])
    else $warning("writeback to non-pending register %0d", $sampled(sel_dest));
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
module tb_rf_writeback_arbiter;
  import rf_pkg::*;

  typedef struct packed {
    wb_req_t req;
    logic    src;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              Alu_Valid, Mem_Valid, Issue_En;
  logic [ADDR_W-1:0] Alu_Dest, Mem_Dest, Issue_Dest, Rd_A, Rd_B;
  logic [DATA_W-1:0] Alu_Data, Mem_Data;
  logic              Alu_Ready, Mem_Ready, Stall;
  logic              RF_Write_En, Grant_Src;
  logic [ADDR_W-1:0] RF_Add_Dest;
  logic [DATA_W-1:0] RF_Write_Data;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];
  exp_t e;

  always #5 CLK = ~CLK;

  rf_writeback_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .Alu_Valid     (Alu_Valid),
    .Alu_Dest      (Alu_Dest),
    .Alu_Data      (Alu_Data),
    .Alu_Ready     (Alu_Ready),
    .Mem_Valid     (Mem_Valid),
    .Mem_Dest      (Mem_Dest),
    .Mem_Data      (Mem_Data),
    .Mem_Ready     (Mem_Ready),
    .Issue_En      (Issue_En),
    .Issue_Dest    (Issue_Dest),
    .Rd_A          (Rd_A),
    .Rd_B          (Rd_B),
    .Stall         (Stall),
    .RF_Write_En   (RF_Write_En),
    .RF_Add_Dest   (RF_Add_Dest),
    .RF_Write_Data (RF_Write_Data),
    .Grant_Src     (Grant_Src)
  );

  function automatic exp_t mk(input logic [ADDR_W-1:0] dest, input logic [DATA_W-1:0] data,
                              input logic src);
    exp_t r;
    r.req.valid = 1'b1;
    r.req.dest  = dest;
    r.req.data  = data;
    r.src       = src;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    Alu_Valid  = 1'b0; Alu_Dest = '0; Alu_Data = '0;
    Mem_Valid  = 1'b0; Mem_Dest = '0; Mem_Data = '0;
    Issue_En   = 1'b0; Issue_Dest = '0; Rd_A = '0; Rd_B = '0;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] dest);
    Issue_En = 1'b1; Issue_Dest = dest; Rd_A = '0; Rd_B = '0;
    tick();
    Issue_En = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    RST_N = 1'b1;
    exp_q.delete();
    tick();
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    set_idle();
    repeat (2) @(posedge CLK);
    #1;
    tests_run++;
    if ({RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got en=%0b dest=%0d data=%h src=%0b, want all 0",
               RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src);
    end
    tests_run++;
    if ({Alu_Ready, Mem_Ready, Stall} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_comb: got ready=%b%b stall=%b, want 000", Alu_Ready, Mem_Ready, Stall);
    end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_single_alu();
    issue(5);
    Alu_Valid = 1'b1; Alu_Dest = 5; Alu_Data = 32'hDEADBEEF;
    #1;
    tests_run++;
    if ({Alu_Ready, Mem_Ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL t1_ready: got alu=%b mem=%b, want alu=1 mem=0", Alu_Ready, Mem_Ready);
    end
    exp_q.push_back(mk(5, 32'hDEADBEEF, SRC_ALU));
    tick();
    Alu_Valid = 1'b0;
    #1;
    if (exp_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL t1_rf: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      tests_run++;
      if ({RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src} !== {1'b1, e.req.dest, e.req.data, e.src}) begin
        tests_failed++;
        $display("FAIL t1_rf: got en=%0b dest=%0d data=%h src=%0b, want en=1 dest=%0d data=%h src=%0b",
                 RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src, e.req.dest, e.req.data, e.src);
      end
    end
    tick();
    tests_run++;
    if ({RF_Write_En, RF_Add_Dest, RF_Write_Data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      tests_failed++;
      $display("FAIL t1_hold: got en=%0b dest=%0d data=%h, want en=0 dest=5 data=deadbeef",
               RF_Write_En, RF_Add_Dest, RF_Write_Data);
    end
  endtask

  task automatic test_round_robin();
    int   na;
    int   nm;
    logic exp_src;
    logic [DATA_W-1:0] exp_data;
    na = 0;
    nm = 0;
    do_reset();
    for (int r = 1; r <= 4; r++) issue(ADDR_W'(r));
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        if (exp_q.size() == 0) begin
          tests_run++; tests_failed++;
          $display("FAIL t2_rf%0d: scoreboard empty", i);
        end else begin
          e = exp_q.pop_front();
          tests_run++;
          if ({RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src} !== {1'b1, e.req.dest, e.req.data, e.src}) begin
            tests_failed++;
            $display("FAIL t2_rf%0d: got en=%0b dest=%0d data=%h src=%0b, want en=1 dest=%0d data=%h src=%0b",
                     i, RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src, e.req.dest, e.req.data, e.src);
          end
        end
      end
      if (i < 4) begin
        Alu_Valid = (na < 2); Alu_Dest = ADDR_W'(1 + 2 * na); Alu_Data = 32'hA000_0000 | (1 + 2 * na);
        Mem_Valid = (nm < 2); Mem_Dest = ADDR_W'(2 + 2 * nm); Mem_Data = 32'hB000_0000 | (2 + 2 * nm);
        exp_src  = (i % 2 == 1);
        exp_data = (exp_src ? 32'hB000_0000 : 32'hA000_0000) | (i + 1);
        #1;
        tests_run++;
        if ({Alu_Ready, Mem_Ready} !== (exp_src ? 2'b01 : 2'b10)) begin
          tests_failed++;
          $display("FAIL t2_grant%0d: got alu=%b mem=%b, want src=%0b", i, Alu_Ready, Mem_Ready, exp_src);
        end
        exp_q.push_back(mk(ADDR_W'(i + 1), exp_data, exp_src));
        if (exp_src) nm++; else na++;
        tick();
      end
    end
    set_idle();
  endtask

  task automatic test_raw_stall();
    issue(7);
    Issue_En = 1'b1; Issue_Dest = 8; Rd_A = 7; Rd_B = 0;
    #1;
    tests_run++;
    if (Stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL t3_stall_raw: got stall=%b, want 1", Stall);
    end
    tick();
    Mem_Valid = 1'b1; Mem_Dest = 7; Mem_Data = 32'h0BAD_F00D;
    #1;
    tests_run++;
    if ({Alu_Ready, Mem_Ready, Stall} !== 3'b011) begin
      tests_failed++;
      $display("FAIL t3_accept: got alu=%b mem=%b stall=%b, want 0 1 1", Alu_Ready, Mem_Ready, Stall);
    end
    exp_q.push_back(mk(7, 32'h0BAD_F00D, SRC_MEM));
    tick();
    Mem_Valid = 1'b0;
    #1;
    if (exp_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL t3_rf: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      tests_run++;
      if ({RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src} !== {1'b1, e.req.dest, e.req.data, e.src}) begin
        tests_failed++;
        $display("FAIL t3_rf: got en=%0b dest=%0d data=%h src=%0b, want en=1 dest=%0d data=%h src=%0b",
                 RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src, e.req.dest, e.req.data, e.src);
      end
    end
    tests_run++;
    if (Stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL t3_stall_commit: got stall=%b, want 1", Stall);
    end
    tick();
    tests_run++;
    if (Stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL t3_release: got stall=%b, want 0", Stall);
    end
    Issue_En = 1'b0;
  endtask

  task automatic test_reg_zero();
    Alu_Valid = 1'b1; Alu_Dest = 0; Alu_Data = 32'h1234;
    Issue_En = 1'b1; Issue_Dest = 0; Rd_A = 0; Rd_B = 0;
    #1;
    tests_run++;
    if (Alu_Ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL t4_ready: got alu_ready=%b, want 1", Alu_Ready);
    end
    tests_run++;
    if (Stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL t4_stall: got stall=%b, want 0", Stall);
    end
    tick();
    Alu_Valid = 1'b0; Issue_En = 1'b0;
    #1;
    tests_run++;
    if (RF_Write_En !== 1'b0) begin
      tests_failed++;
      $display("FAIL t4_no_write: got en=%b, want 0", RF_Write_En);
    end
  endtask

  task automatic test_same_edge();
    Alu_Valid = 1'b1; Alu_Dest = 9; Alu_Data = 32'h9999_0009;
    #1;
    tests_run++;
    if (Alu_Ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL t5_accept: got alu_ready=%b, want 1", Alu_Ready);
    end
    exp_q.push_back(mk(9, 32'h9999_0009, SRC_ALU));
    tick();
    Alu_Valid = 1'b0;
    Issue_En = 1'b1; Issue_Dest = 9; Rd_A = 0; Rd_B = 0;
    #1;
    if (exp_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL t5_rf: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      tests_run++;
      if ({RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src} !== {1'b1, e.req.dest, e.req.data, e.src}) begin
        tests_failed++;
        $display("FAIL t5_rf: got en=%0b dest=%0d data=%h src=%0b, want en=1 dest=%0d data=%h src=%0b",
                 RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src, e.req.dest, e.req.data, e.src);
      end
    end
    tests_run++;
    if (Stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL t5_issue_ok: got stall=%b, want 0", Stall);
    end
    tick();
    Issue_Dest = 10; Rd_B = 9;
    #1;
    tests_run++;
    if (Stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL t5_set_wins: got stall=%b, want 1", Stall);
    end
    Issue_En = 1'b0;
    repeat (3) tick();
    Issue_En = 1'b1;
    #1;
    tests_run++;
    if (Stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL t5_still_pending: got stall=%b, want 1", Stall);
    end
    Issue_En = 1'b0;
  endtask

  task automatic test_async_reset();
    issue(12);
    Alu_Valid = 1'b1; Alu_Dest = 12; Alu_Data = 32'hC0DE_000C;
    #1;
    tests_run++;
    if (Alu_Ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL t6_accept: got alu_ready=%b, want 1", Alu_Ready);
    end
    tick();
    Alu_Valid = 1'b0;
    #1;
    tests_run++;
    if (RF_Write_En !== 1'b1) begin
      tests_failed++;
      $display("FAIL t6_pre: got en=%b, want 1", RF_Write_En);
    end
    #1 RST_N = 1'b0;
    exp_q.delete();
    #1;
    tests_run++;
    if ({RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src} !== '0) begin
      tests_failed++;
      $display("FAIL t6_async_clear: got en=%0b dest=%0d data=%h src=%0b, want all 0",
               RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src);
    end
    #1 RST_N = 1'b1;
    tick();
    tests_run++;
    if (RF_Write_En !== 1'b0) begin
      tests_failed++;
      $display("FAIL t6_dropped: got en=%b, want 0", RF_Write_En);
    end
    Issue_En = 1'b1; Issue_Dest = 13; Rd_A = 12; Rd_B = 9;
    #1;
    tests_run++;
    if (Stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL t6_pending_cleared: got stall=%b, want 0", Stall);
    end
    Issue_En = 1'b0;
    issue(14);
    issue(15);
    Alu_Valid = 1'b1; Alu_Dest = 14; Alu_Data = 32'hAAAA_000E;
    Mem_Valid = 1'b1; Mem_Dest = 15; Mem_Data = 32'hBBBB_000F;
    #1;
    tests_run++;
    if ({Alu_Ready, Mem_Ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL t6_alu_first: got alu=%b mem=%b, want alu=1 mem=0", Alu_Ready, Mem_Ready);
    end
    exp_q.push_back(mk(14, 32'hAAAA_000E, SRC_ALU));
    tick();
    Alu_Valid = 1'b0;
    #1;
    if (exp_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL t6_rf_alu: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      tests_run++;
      if ({RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src} !== {1'b1, e.req.dest, e.req.data, e.src}) begin
        tests_failed++;
        $display("FAIL t6_rf_alu: got en=%0b dest=%0d data=%h src=%0b, want en=1 dest=%0d data=%h src=%0b",
                 RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src, e.req.dest, e.req.data, e.src);
      end
    end
    tests_run++;
    if (Mem_Ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL t6_mem_next: got mem_ready=%b, want 1", Mem_Ready);
    end
    exp_q.push_back(mk(15, 32'hBBBB_000F, SRC_MEM));
    tick();
    Mem_Valid = 1'b0;
    #1;
    if (exp_q.size() == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL t6_rf_mem: scoreboard empty");
    end else begin
      e = exp_q.pop_front();
      tests_run++;
      if ({RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src} !== {1'b1, e.req.dest, e.req.data, e.src}) begin
        tests_failed++;
        $display("FAIL t6_rf_mem: got en=%0b dest=%0d data=%h src=%0b, want en=1 dest=%0d data=%h src=%0b",
                 RF_Write_En, RF_Add_Dest, RF_Write_Data, Grant_Src, e.req.dest, e.req.data, e.src);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_alu();
    test_round_robin();
    test_raw_stall();
    test_reg_zero();
    test_same_edge();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
